tlb_query_unit: RTL

Owns the TLB entry array and answers the CP0 query instructions: it absorbs `tlbwrite_t` writes coming from the TLBWI path and serves TLBP (probe) and TLBR (read) requests, returning EntryHi/EntryLo0/EntryLo1/Index values for CP0 to latch. It sits beside CP0 in the memory stage. The execute pipeline stalls on `req_ready`/`resp_valid`. Probes scan the array one entry per cycle unless the parallel-compare build option is enabled.

---
 rtl/tlb_query_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tlb_query_unit.sv
// tlb_query_unit: TLB entry array with the CP0 query engine (TLBP/TLBR).
//
// The file also holds tlb_query_pkg, which defines the entry and write-port
// types shared with CP0.
//
// Ports
//   clk, resetn     rising-edge clock, asynchronous active-low reset
//   wr              TLBWI write port (valid/addr/data), accepted in every state
//   req_valid/ready request handshake, ready only while idle
//   req_is_tlbp     1 = probe (TLBP), 0 = read (TLBR)
//   req_entryhi     probe key: VPN2 in [31:13], ASID in [7:0]
//   req_index       TLBR index (low $clog2(TLB_ENTRIES) bits used)
//   resp_valid/ready response handshake, outputs held until retired
//   resp_entryhi/entrylo0/entrylo1  TLBR results
//   resp_index      TLBP result, bit31 set on miss
//
// Build option
//   TLB_PROBE_PARALLEL_EN  when defined, TLBP compares every entry in the
//                          accept cycle via a priority encoder; otherwise the
//                          probe scans one entry per cycle with one comparator.

package tlb_query_pkg;
  localparam int TLB_INDEX = 4;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [TLB_INDEX-1:0] addr;
    tlb_entry_t           data;
  } tlbwrite_t;
endpackage

module tlb_query_unit
  import tlb_query_pkg::*;
#(
  parameter int TLB_ENTRIES = 2 ** TLB_INDEX
) (
  input  logic        clk,
  input  logic        resetn,
  input  tlbwrite_t   wr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_tlbp,
  input  logic [31:0] req_entryhi,
  input  logic [31:0] req_index,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_entryhi,
  output logic [31:0] resp_entrylo0,
  output logic [31:0] resp_entrylo1,
  output logic [31:0] resp_index
);

  localparam int IW = $clog2(TLB_ENTRIES);
  localparam logic [IW-1:0] LAST = IW'(TLB_ENTRIES - 1);
  localparam logic [31:0] MISS_INDEX = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t      state, state_next;
  tlb_entry_t  tlb [TLB_ENTRIES];
  logic [IW-1:0] cnt;
  logic [18:0] key_vpn2;
  logic [7:0]  key_asid;
  logic        accept;
  logic        scan_hit;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Bits of the request words that carry no meaning for this unit.
  logic unused_bits;
  assign unused_bits = ^{req_entryhi[12:8], req_index[31:IW]};

  function automatic logic entry_match(input tlb_entry_t e,
                                       input logic [18:0] vpn2,
                                       input logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  function automatic logic [31:0] fmt_entryhi(input tlb_entry_t e);
    return {e.vpn2, 5'b0, e.asid};
  endfunction

  function automatic logic [31:0] fmt_entrylo0(input tlb_entry_t e);
    return {6'b0, e.pfn0, e.c0, e.d0, e.v0, e.g};
  endfunction

  function automatic logic [31:0] fmt_entrylo1(input tlb_entry_t e);
    return {6'b0, e.pfn1, e.c1, e.d1, e.v1, e.g};
  endfunction

  assign accept   = req_valid && req_ready;
  assign wr_idx   = IW'(wr.addr);
  assign rd_idx   = req_index[IW-1:0];
  // The scan reads the array as it stood before the current edge, so a write
  // landing on a not-yet-examined entry is picked up naturally.
  assign scan_hit = entry_match(tlb[cnt], key_vpn2, key_asid);

`ifdef TLB_PROBE_PARALLEL_EN
  logic          par_hit;
  logic [IW-1:0] par_idx;

  // Descending walk so the lowest matching index is the one left standing.
  always_comb begin
    par_hit = 1'b0;
    par_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match(tlb[i], req_entryhi[31:13], req_entryhi[7:0])) begin
        par_hit = 1'b1;
        par_idx = IW'(i);
      end
    end
  end
`endif

  // Entry array: writes are honoured regardless of FSM state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) tlb[i] <= '0;
    end else if (wr.valid) begin
      tlb[wr_idx] <= wr.data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef TLB_PROBE_PARALLEL_EN
          state_next = RESP;
`else
          state_next = req_is_tlbp ? SCAN : RESP;
`endif
        end
      end
      SCAN: if (scan_hit || (cnt == LAST)) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Query datapath: latched key, scan counter and response registers.
  // TLBP touches only resp_index; TLBR touches only the entry words.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      key_vpn2      <= '0;
      key_asid      <= '0;
      resp_entryhi  <= '0;
      resp_entrylo0 <= '0;
      resp_entrylo1 <= '0;
      resp_index    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_is_tlbp) begin
              key_vpn2 <= req_entryhi[31:13];
              key_asid <= req_entryhi[7:0];
              cnt      <= '0;
`ifdef TLB_PROBE_PARALLEL_EN
              resp_index <= par_hit ? {{(32-IW){1'b0}}, par_idx} : MISS_INDEX;
`endif
            end else begin
              resp_entryhi  <= fmt_entryhi(tlb[rd_idx]);
              resp_entrylo0 <= fmt_entrylo0(tlb[rd_idx]);
              resp_entrylo1 <= fmt_entrylo1(tlb[rd_idx]);
            end
          end
        end
        SCAN: begin
          if (scan_hit) begin
            resp_index <= {{(32-IW){1'b0}}, cnt};
          end else if (cnt == LAST) begin
            resp_index <= MISS_INDEX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
